// File: rtl/lvds_link_pkg.sv
// Shared LVDS link definitions: framed-word layout, training constants and a framing helper.
package lvds_link_pkg;

    localparam int LINK_WORD_W = 32;
    localparam int VALID_BIT   = 31;
    localparam int SEQ_MSB     = 30;
    localparam int SEQ_LSB     = 24;

    localparam logic [7:0] TRAIN_ALIGN = 8'h35;
    localparam logic [7:0] TRAIN_START = 8'h77;

    typedef struct packed {
        logic                     valid;
        logic [SEQ_MSB-SEQ_LSB:0] seq;
        logic [SEQ_LSB-1:0]       payload;
    } link_word_t;

    function automatic logic [LINK_WORD_W-1:0] frame_word(
        input logic [SEQ_MSB-SEQ_LSB:0] seq,
        input logic [SEQ_LSB-1:0]       payload
    );
        link_word_t w;
        w.valid   = 1'b1;
        w.seq     = seq;
        w.payload = payload;
        frame_word = w;
    endfunction

endpackage

// File: rtl/lvds_fifo_mem.sv
// Payload storage for the transmit FIFO: synchronous write, asynchronous read.
module lvds_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 24
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lvds_tx_word_fifo.sv
// Transmit-side word FIFO: buffers payloads and presents sequence-numbered framed words
// to the LVDS serialiser with first-word-fall-through timing.
module lvds_tx_word_fifo
    import lvds_link_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 24,
    parameter int SEQ_W  = 7
) (
    input  logic                   tx_inclock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LINK_WORD_W-1:0] enq_tx,
    output logic                   RDY_enq_tx,
    input  logic                   EN_enq_tx,
    output logic [ADDR_W:0]        count,
    output logic                   underflow_err
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
    localparam logic [SEQ_W-1:0]  SEQ_ONE  = SEQ_W'(1);
    localparam logic [SEQ_W-1:0]  SEQ_ZERO = SEQ_W'(0);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [SEQ_W-1:0]  r_seq_cnt;
    logic              r_underflow;

    logic              w_rdy;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_data;

    // Ready and availability come only from registered state, never from EN_enq_tx
    assign in_ready = reset_n && (r_count != FULL_CNT);
    assign w_rdy    = (r_count != CNT_ZERO);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = EN_enq_tx && w_rdy;
    assign w_wr_en  = w_push && !flush;

    lvds_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .i_clk     (tx_inclock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Pointer, occupancy, sequence and underflow state
    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            r_wr_ptr    <= PTR_ZERO;
            r_rd_ptr    <= PTR_ZERO;
            r_count     <= CNT_ZERO;
            r_seq_cnt   <= SEQ_ZERO;
            r_underflow <= 1'b0;
        end else begin
            if (EN_enq_tx && !w_rdy) begin
                r_underflow <= 1'b1;
            end else begin
                r_underflow <= r_underflow;
            end

            if (flush) begin
                // Sequence counter survives so the far end sees the flushed words as a gap
                r_wr_ptr <= PTR_ZERO;
                r_rd_ptr <= PTR_ZERO;
                r_count  <= CNT_ZERO;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end else begin
                    r_wr_ptr <= r_wr_ptr;
                end

                if (w_pop) begin
                    r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                    r_seq_cnt <= r_seq_cnt + SEQ_ONE;
                end else begin
                    r_rd_ptr  <= r_rd_ptr;
                    r_seq_cnt <= r_seq_cnt;
                end

                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Framed output: marker and sequence are appended at read time
    always_comb begin
        enq_tx = {LINK_WORD_W{1'b0}};
        if (w_rdy) begin
            enq_tx = frame_word(r_seq_cnt, w_rd_data);
        end else begin
            enq_tx = {LINK_WORD_W{1'b0}};
        end
    end

    assign RDY_enq_tx    = w_rdy;
    assign count         = r_count;
    assign underflow_err = r_underflow;

endmodule

// File: tb/tb_lvds_tx_word_fifo.sv
// Directed self-checking bench for lvds_tx_word_fifo.
module tb_lvds_tx_word_fifo;

    logic        tx_inclock;
    logic        reset_n;
    logic        flush;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] enq_tx;
    logic        RDY_enq_tx;
    logic        EN_enq_tx;
    logic [4:0]  count;
    logic        underflow_err;

    int total;
    int bad;

    lvds_tx_word_fifo dut (
        .tx_inclock    (tx_inclock),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .enq_tx        (enq_tx),
        .RDY_enq_tx    (RDY_enq_tx),
        .EN_enq_tx     (EN_enq_tx),
        .count         (count),
        .underflow_err (underflow_err)
    );

    initial tx_inclock = 1'b0;
    always #5 tx_inclock = ~tx_inclock;

    task automatic tick();
        @(posedge tx_inclock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        EN_enq_tx = 1'b0;
        in_data   = 24'h0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic push_one(input logic [23:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        EN_enq_tx = 1'b1;
        tick();
        EN_enq_tx = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        EN_enq_tx = 1'b0;
        in_data   = 24'h0;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_in_ready_low got=%0b exp=0", in_ready);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++;
        if (RDY_enq_tx !== 1'b0) begin bad++; $display("FAIL rst_rdy got=%0b exp=0", RDY_enq_tx); end
        total++;
        if (enq_tx !== 32'h0) begin bad++; $display("FAIL rst_enq got=%h exp=00000000", enq_tx); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        total++;
        if (underflow_err !== 1'b0) begin bad++; $display("FAIL rst_uflow got=%0b exp=0", underflow_err); end
    endtask

    task automatic test_single();
        push_one(24'hABCDEF);
        total++;
        if (enq_tx !== 32'h80ABCDEF) begin bad++; $display("FAIL single_word got=%h exp=80ABCDEF", enq_tx); end
        total++;
        if (count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        pop_one();
        total++;
        if (RDY_enq_tx !== 1'b0 || enq_tx !== 32'h0) begin
            bad++; $display("FAIL single_empty got rdy=%0b enq=%h exp rdy=0 enq=00000000", RDY_enq_tx, enq_tx);
        end
        push_one(24'h000111);
        total++;
        if (enq_tx !== 32'h81000111) begin bad++; $display("FAIL single_seq1 got=%h exp=81000111", enq_tx); end
        pop_one();
    endtask

    task automatic test_fill();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) push_one(24'(i));
        total++;
        if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", count); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
        total++;
        if (enq_tx !== 32'h80000000) begin bad++; $display("FAIL fill_first got=%h exp=80000000", enq_tx); end
        in_data   = 24'h000010;
        in_valid  = 1'b1;
        EN_enq_tx = 1'b1;
        tick();
        in_valid  = 1'b0;
        EN_enq_tx = 1'b0;
        total++;
        if (count !== 5'd15) begin bad++; $display("FAIL fill_refused_count got=%0d exp=15", count); end
        for (int i = 1; i < 16; i++) begin
            exp = {1'b1, 7'(i), 24'(i)};
            total++;
            if (enq_tx !== exp) begin bad++; $display("FAIL fill_drain[%0d] got=%h exp=%h", i, enq_tx, exp); end
            pop_one();
        end
        total++;
        if (count !== 5'd0 || RDY_enq_tx !== 1'b0) begin
            bad++; $display("FAIL fill_after_drain got count=%0d rdy=%0b exp count=0 rdy=0", count, RDY_enq_tx);
        end
    endtask

    task automatic test_seq_wrap();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 130; i++) begin
            push_one(24'h000001);
            exp = {1'b1, 7'(i), 24'h000001};
            total++;
            if (enq_tx !== exp) begin bad++; $display("FAIL seq_wrap[%0d] got=%h exp=%h", i, enq_tx, exp); end
            pop_one();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) push_one(24'hA00000 + 24'(i));
        for (int k = 0; k < 10; k++) begin
            exp = {1'b1, 7'(k), 24'hA00000 + 24'(k)};
            total++;
            if (enq_tx !== exp) begin bad++; $display("FAIL b2b_word[%0d] got=%h exp=%h", k, enq_tx, exp); end
            in_data   = 24'hA00005 + 24'(k);
            in_valid  = 1'b1;
            EN_enq_tx = 1'b1;
            tick();
            total++;
            if (count !== 5'd5) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=5", k, count); end
        end
        in_valid  = 1'b0;
        EN_enq_tx = 1'b0;
        for (int k = 10; k < 15; k++) begin
            exp = {1'b1, 7'(k), 24'hA00000 + 24'(k)};
            total++;
            if (enq_tx !== exp) begin bad++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", k, enq_tx, exp); end
            pop_one();
        end
        total++;
        if (underflow_err !== 1'b0) begin bad++; $display("FAIL uflow_pre got=%0b exp=0", underflow_err); end
        pop_one();
        total++;
        if (underflow_err !== 1'b1) begin bad++; $display("FAIL uflow_set got=%0b exp=1", underflow_err); end
        total++;
        if (count !== 5'd0 || RDY_enq_tx !== 1'b0) begin
            bad++; $display("FAIL uflow_state got count=%0d rdy=%0b exp count=0 rdy=0", count, RDY_enq_tx);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_one(24'h000055);
            pop_one();
        end
        pop_one();
        for (int i = 0; i < 7; i++) push_one(24'h000070 + 24'(i));
        total++;
        if (count !== 5'd7) begin bad++; $display("FAIL flush_pre_count got=%0d exp=7", count); end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 24'h0000EE;
        EN_enq_tx = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        EN_enq_tx = 1'b0;
        total++;
        if (count !== 5'd0 || RDY_enq_tx !== 1'b0 || enq_tx !== 32'h0) begin
            bad++; $display("FAIL flush_clear got count=%0d rdy=%0b enq=%h exp 0/0/00000000", count, RDY_enq_tx, enq_tx);
        end
        total++;
        if (underflow_err !== 1'b1) begin bad++; $display("FAIL flush_keeps_uflow got=%0b exp=1", underflow_err); end
        push_one(24'h123456);
        total++;
        if (enq_tx !== 32'h83123456) begin bad++; $display("FAIL flush_seq got=%h exp=83123456", enq_tx); end
        pop_one();
        // reset in the middle of a push burst
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 24'h000200 + 24'(i);
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        total++;
        if (count !== 5'd0 || RDY_enq_tx !== 1'b0 || underflow_err !== 1'b0) begin
            bad++; $display("FAIL midreset got count=%0d rdy=%0b uflow=%0b exp 0/0/0", count, RDY_enq_tx, underflow_err);
        end
        push_one(24'h000042);
        total++;
        if (enq_tx !== 32'h80000042) begin bad++; $display("FAIL midreset_seq got=%h exp=80000042", enq_tx); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_fill();
        test_seq_wrap();
        test_back_to_back();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
